// File: rtl/vp_pkg.sv
// Shared definitions for the vector-processor instruction sequencer:
// instruction layout, opcode encodings and sequencer FSM states.
package vp_pkg;

  localparam int INSTR_W  = 13;
  localparam int OP_MSB   = 12;
  localparam int OP_LSB   = 11;
  localparam int REG_MSB  = 10;
  localparam int REG_LSB  = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_ADD   = 2'b10,
    OP_MUL   = 2'b11
  } opcode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

endpackage

// File: rtl/vp_instr_fifo.sv
// Synchronous instruction FIFO with a flush that clears pointers and count
// while still letting a same-edge pop read the old head.
module vp_instr_fifo
  import vp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [INSTR_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [INSTR_W-1:0]       head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/vp_instr_sequencer.sv
// Issues buffered vector instructions to the processor one at a time, holding
// each for a per-opcode window and chaining the next issue with no bubble.
module vp_instr_sequencer
  import vp_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LAT_LOAD  = 10,
  parameter int LAT_STORE = 10,
  parameter int LAT_ADD   = 10,
  parameter int LAT_MUL   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     pause,
  input  logic                     flush,
  output logic [INSTR_W-1:0]       instr,
  output logic                     instr_valid,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              retired
);

  state_t             state;
  state_t             state_next;
  logic [7:0]         cnt;
  logic [7:0]         cnt_next;
  logic [7:0]         lat_sel;
  logic [INSTR_W-1:0] instr_next;
  logic [INSTR_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               issue;
  opcode_t            head_op;

  vp_instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_instr),
    .pop       (issue),
    .flush     (flush),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready    = !fifo_full;
  assign instr_valid = (state == ST_EXEC);
  assign busy        = instr_valid || !fifo_empty;
  // Decoded purely from registers so the processor never sees an input-driven glitch.
  assign done        = (state == ST_EXEC) && (cnt == 8'd0);

  always_comb begin
    head_op = opcode_t'(head[OP_MSB:OP_LSB]);
    case (head_op)
      OP_LOAD:  lat_sel = 8'(LAT_LOAD);
      OP_STORE: lat_sel = 8'(LAT_STORE);
      OP_ADD:   lat_sel = 8'(LAT_ADD);
      default:  lat_sel = 8'(LAT_MUL);
    endcase
  end

  // Issue happens from IDLE or in the last window cycle, which gives back-to-back windows.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    instr_next = instr;
    issue      = !pause && !fifo_empty && ((state == ST_IDLE) || done);
    if (issue) begin
      state_next = ST_EXEC;
      cnt_next   = lat_sel - 8'd1;
      instr_next = {head[OP_MSB:OP_LSB], head[REG_MSB:REG_LSB], head[ADDR_MSB:ADDR_LSB]};
    end else if (done) begin
      state_next = ST_IDLE;
    end else if (state == ST_EXEC) begin
      cnt_next = cnt - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 8'd0;
      instr   <= '0;
      retired <= 16'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      instr   <= instr_next;
      retired <= retired + 16'(done);
    end
  end

endmodule

// File: tb/tb_vp_instr_sequencer.sv
// Randomized bench for vp_instr_sequencer against a queue-based reference model.
module tb_vp_instr_sequencer;

  localparam int DEPTH     = 8;
  localparam int LAT_LOAD  = 10;
  localparam int LAT_STORE = 4;
  localparam int LAT_ADD   = 1;
  localparam int LAT_MUL   = 3;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [12:0]   in_instr;
  logic          in_valid;
  logic          in_ready;
  logic          pause;
  logic          flush;
  logic [12:0]   instr;
  logic          instr_valid;
  logic          done;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic [15:0]   retired;

  int num_checks;
  int num_fails;

  logic [12:0] m_queue [$];
  bit          m_active;
  int          m_rem;
  logic [12:0] m_instr;
  logic [15:0] m_retired;

  vp_instr_sequencer #(
    .DEPTH     (DEPTH),
    .LAT_LOAD  (LAT_LOAD),
    .LAT_STORE (LAT_STORE),
    .LAT_ADD   (LAT_ADD),
    .LAT_MUL   (LAT_MUL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_instr    (in_instr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pause       (pause),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .done        (done),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .retired     (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input logic [12:0] ins);
    case (ins[12:11])
      2'b00:   return LAT_LOAD;
      2'b01:   return LAT_STORE;
      2'b10:   return LAT_ADD;
      default: return LAT_MUL;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s at %0t: observed %0h, required %0h", tag, $time, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and advances the model across the coming edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [12:0] d, input bit p, input bit f);
    bit can_push;
    rst      = r;
    in_valid = v;
    in_instr = d;
    pause    = p;
    flush    = f;
    if (r) begin
      m_queue.delete();
      m_active  = 0;
      m_rem     = 0;
      m_instr   = '0;
      m_retired = '0;
    end else begin
      can_push = v && (m_queue.size() < DEPTH);
      if (m_active) begin
        if (m_rem > 1) begin
          m_rem--;
        end else begin
          m_retired++;
          m_active = 0;
        end
      end
      if (!m_active && m_queue.size() > 0 && !p) begin
        m_instr  = m_queue.pop_front();
        m_active = 1;
        m_rem    = lat_of(m_instr);
      end
      if (f) m_queue.delete();
      else if (can_push) m_queue.push_back(d);
    end
  endtask

  task automatic stepCycle(input bit r, input bit v, input logic [12:0] d, input bit p, input bit f);
    @(negedge clk);
    checkOutput("instr_valid", 32'(instr_valid), 32'(m_active));
    checkOutput("done", 32'(done), 32'(m_active && m_rem == 1));
    checkOutput("busy", 32'(busy), 32'(m_active || m_queue.size() > 0));
    checkOutput("fifo_count", 32'(fifo_count), 32'(m_queue.size()));
    checkOutput("in_ready", 32'(in_ready), 32'(m_queue.size() < DEPTH));
    checkOutput("instr", 32'(instr), 32'(m_instr));
    checkOutput("retired", 32'(retired), 32'(m_retired));
    applyStimulus(r, v, d, p, f);
  endtask

  task automatic idleCycles(input int n, input bit p);
    for (int i = 0; i < n; i++) stepCycle(0, 0, 13'h0, p, 0);
  endtask

  function automatic logic [12:0] rand_instr();
    return 13'($urandom);
  endfunction

  initial begin
    num_checks = 0;
    num_fails  = 0;
    applyStimulus(1, 0, 13'h0, 0, 0);
    stepCycle(1, 0, 13'h0, 0, 0);

    // Single load R1 @ 0x014.
    stepCycle(0, 1, {2'b00, 2'b00, 9'h014}, 0, 0);
    idleCycles(14, 0);

    // Four back-to-back instructions.
    stepCycle(0, 1, {2'b00, 2'b00, 9'h014}, 0, 0);
    stepCycle(0, 1, {2'b00, 2'b10, 9'h015}, 0, 0);
    stepCycle(0, 1, {2'b11, 2'b01, 9'h1a0}, 0, 0);
    stepCycle(0, 1, {2'b10, 2'b11, 9'h0ff}, 0, 0);
    idleCycles(25, 0);

    // Overfill while a store executes.
    stepCycle(0, 1, {2'b01, 2'b01, 9'h033}, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) stepCycle(0, 1, rand_instr(), 0, 0);
    idleCycles(60, 0);

    // Pause with entries queued, then release.
    stepCycle(0, 1, {2'b00, 2'b00, 9'h001}, 0, 0);
    for (int i = 0; i < 3; i++) stepCycle(0, 1, rand_instr(), 1, 0);
    idleCycles(15, 1);
    idleCycles(40, 0);

    // Flush mid-window.
    for (int i = 0; i < 3; i++) stepCycle(0, 1, {2'b00, 2'(i), 9'(i)}, 0, 0);
    idleCycles(3, 0);
    stepCycle(0, 0, 13'h0, 0, 1);
    idleCycles(20, 0);

    // Reset partway through a load window.
    stepCycle(0, 1, {2'b00, 2'b01, 9'h07f}, 0, 0);
    idleCycles(5, 0);
    stepCycle(1, 0, 13'h0, 0, 0);
    idleCycles(5, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      stepCycle($urandom_range(0, 399) == 0,
                $urandom_range(0, 99) < 55,
                rand_instr(),
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 3);
    end
    idleCycles(40, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/vp_instr_sequencer.md
# vp_instr_sequencer

Instruction sequencer sitting in front of the `Processor` vector core. It accepts 13-bit vector instructions from a host over a valid/ready stream and buffers them in a small FIFO. It issues them to the processor one at a time, holding each instruction stable for a per-opcode execution window before retiring it and issuing the next. This replaces hand-timed instruction driving with a cycle-exact, back-to-back schedule.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `LAT_LOAD`, 10: cycles an opcode-00 (load mem→reg) instruction is held; legal range 1..255.
- `LAT_STORE`, 10: cycles for opcode 01 (store reg→mem); 1..255.
- `LAT_ADD`, 10: cycles for opcode 10 (ALU add); 1..255.
- `LAT_MUL`, 10: cycles for opcode 11 (ALU multiply); 1..255.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_instr` in 13: instruction. [12:11] opcode, [10:9] register select (R1..R4), [8:0] memory address.
- `in_valid` in 1: host offers `in_instr`.
- `in_ready` out 1: equals `!full`; the instruction is accepted on an edge where `in_valid & in_ready`.
- `pause` in 1: while high, no new issue; the in-flight instruction still completes.
- `flush` in 1: one-cycle request; empties the FIFO without affecting the in-flight instruction.
- `instr` out 13: instruction driven to the processor.
- `instr_valid` out 1: `instr` is live and the processor must execute it.
- `done` out 1: one-cycle pulse in the final cycle of an instruction's window.
- `busy` out 1: high when in EXEC or the FIFO is non-empty.
- `fifo_count` out $clog2(DEPTH)+1: number of buffered, not-yet-issued entries.
- `retired` out 16: count of retired instructions; wraps 0xFFFF→0.

## Operation
- FSM states:
  - IDLE: `instr_valid`=0.
  - EXEC: `instr_valid`=1 and an 8-bit down-counter `cnt` is running.
- Issue: on any edge where state is IDLE, the FIFO is non-empty and `pause`=0:
  - pop the head into the `instr` register;
  - load `cnt` with LAT(opcode)−1;
  - go to EXEC.
- EXEC with `cnt`≠0: decrement `cnt`; `instr` is held constant.
- EXEC with `cnt`=0:
  - `done`=1 in this cycle (decoded from registers, no combinational path from inputs).
  - At the edge, `retired` increments.
  - If the FIFO is non-empty and `pause`=0, the next head is popped and issued at this same edge. There is no bubble.
  - Otherwise go to IDLE.
- `instr` keeps its last value in IDLE; consumers gate on `instr_valid`.
- Push and pop on the same edge are both performed. A push is refused when full, even if a pop occurs on that edge.
- `flush`:
  - Clears the FIFO pointers and `fifo_count` at the edge.
  - A push on the same edge is discarded.
  - A pop on the same edge still issues the popped head.
- Opcode fields are not validated; all four encodings are legal.
- The register and address fields pass through unmodified.

## Timing
- Reset values: `instr`=0, `instr_valid`=0, `done`=0, `busy`=0, `fifo_count`=0, `retired`=0, `in_ready`=1, state IDLE, `cnt`=0.
- Reset mid-operation aborts the in-flight instruction. `instr_valid` is 0 in the cycle after the reset edge, and no `done` is generated.
- Latency: instruction accepted at edge N into an empty, idle sequencer → `instr_valid`=1 from edge N+1. It stays high for exactly LAT cycles; `done` is high in cycle N+LAT.
- Back-to-back: K queued instructions occupy ΣLAT consecutive cycles with `instr_valid` continuously high.
- `pause` is sampled only at issue edges. Asserting it mid-window does not stretch the window.

## Structure
- Shared package `vp_pkg`:
  - `INSTR_W`=13;
  - opcode enum OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_MUL=2'b11;
  - field bit positions;
  - FSM state enum.
- Sub-module `vp_instr_fifo`: synchronous FIFO, parameter `DEPTH`, with push/pop/flush/full/empty/count. The sequencer top holds the FSM, latency decode, counter and `retired`.

## Test plan
- Reset, then push load R1@0x014 → `instr_valid` rises one cycle after accept, lasts 10 cycles, `done` pulses once, `retired`=1, then IDLE.
- Push load R1@0x014, load R3@0x015, mul, add in consecutive cycles → `instr_valid` high 40 contiguous cycles, opcodes issued in order, 4 `done` pulses 10 cycles apart, `retired`=4.
- Override LAT_MUL=3, LAT_ADD=1 → mul window 3 cycles, add window 1 cycle with `done` in that same cycle.
- Fill FIFO with DEPTH+1 pushes while a store executes → `in_ready`=0 at `fifo_count`=DEPTH, extra push refused, `in_ready` returns the cycle after the next pop.
- `pause` high with 3 entries queued → the current instruction finishes, IDLE, `fifo_count` stays 3; deassert → issue on the next edge. `flush` mid-window → `fifo_count`=0, current instruction still retires.
- Assert `rst` at cycle 5 of a 10-cycle window → all outputs return to reset values the next cycle, no `done`, `retired`=0.
